// File: rtl/control_module_if.sv
// control_module_if
//   Byte-wide register images exchanged between the MCU register bridge and
//   the sample-capture / tone-analysis engine.
//   MCU -> block : myRegMCUStatuslsb/msb (control), myRegSampleInlsb/msb (sample)
//   block -> MCU : myRegASICStatuslsb/msb (status, crossing count),
//                  myRegResultslsb/msb (mean absolute amplitude)
//   master modport = MCU/bridge side, slave modport = engine side.
interface control_module_if;
  logic [7:0] myRegMCUStatuslsb;
  logic [7:0] myRegMCUStatusmsb;
  logic [7:0] myRegSampleInlsb;
  logic [7:0] myRegSampleInmsb;
  logic [7:0] myRegASICStatuslsb;
  logic [7:0] myRegASICStatusmsb;
  logic [7:0] myRegResultslsb;
  logic [7:0] myRegResultsmsb;

  modport master (
    output myRegMCUStatuslsb,
    output myRegMCUStatusmsb,
    output myRegSampleInlsb,
    output myRegSampleInmsb,
    input  myRegASICStatuslsb,
    input  myRegASICStatusmsb,
    input  myRegResultslsb,
    input  myRegResultsmsb
  );

  modport slave (
    input  myRegMCUStatuslsb,
    input  myRegMCUStatusmsb,
    input  myRegSampleInlsb,
    input  myRegSampleInmsb,
    output myRegASICStatuslsb,
    output myRegASICStatusmsb,
    output myRegResultslsb,
    output myRegResultsmsb
  );
endinterface

// File: rtl/control_module.sv
// control_module
//   Captures a frame of N_SAMPLES signed 16-bit samples through a four-phase
//   register handshake (REQ from the block, SAMPLE_VALID from the MCU) and
//   reports the frame's mean absolute amplitude and zero-crossing count.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : control_module_if.slave
//     MCUStatuslsb  bit0 ABORT, bit2 START, bit3 SAMPLE_VALID (rest ignored)
//     MCUStatusmsb  ignored
//     SampleIn      sample {msb,lsb}, two's complement
//     ASICStatuslsb bit0 IDLE, bit1 DONE, bit2 ACTIVE, bit3 REQ
//     ASICStatusmsb zero-crossing count of the last completed frame
//     Results       mean absolute amplitude of the last completed frame
// All outputs come straight from flops.
module control_module #(
  parameter int N_SAMPLES = 128,
  parameter int LOG_N     = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  control_module_if.slave   bus
);

  localparam int CNT_W = LOG_N + 1;
  localparam int ACC_W = 16 + LOG_N;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_SAMPLE  = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] ST_DONE         = 2'd3;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(N_SAMPLES);

  // Status image for a given state: {4'b0, REQ, ACTIVE, DONE, IDLE}
  function automatic logic [7:0] status_of(input logic [1:0] st);
    logic [7:0] img;
    case (st)
      ST_IDLE:         img = 8'h01;
      ST_WAIT_SAMPLE:  img = 8'h0C;
      ST_WAIT_RELEASE: img = 8'h04;
      ST_DONE:         img = 8'h02;
      default:         img = 8'h01;
    endcase
    return img;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             start_prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] acc_r;
  logic [7:0]       cross_r;
  logic             prev_neg_r;
  logic [7:0]       status_r;
  logic [7:0]       zc_r;
  logic [15:0]      result_r;

  logic             abort_s;
  logic             start_s;
  logic             valid_s;
  logic             start_rise_s;
  logic [15:0]      sample_s;
  logic [16:0]      sample_ext_s;
  logic [16:0]      abs_s;
  logic [ACC_W-1:0] acc_next_s;
  logic [7:0]       cross_next_s;
  logic [15:0]      result_next_s;
  logic             capture_s;
  logic             last_s;
  logic             enter_frame_s;
  logic             unused_bits_s;

  // Control bit decode and START edge detection
  always_comb begin
    abort_s       = bus.myRegMCUStatuslsb[0];
    start_s       = bus.myRegMCUStatuslsb[2];
    valid_s       = bus.myRegMCUStatuslsb[3];
    start_rise_s  = start_s & ~start_prev_r;
    unused_bits_s = ^{bus.myRegMCUStatusmsb, bus.myRegMCUStatuslsb[7:4],
                      bus.myRegMCUStatuslsb[1]};
  end

  // Sample datapath: magnitude, accumulation, crossing detection, result
  always_comb begin
    sample_s     = {bus.myRegSampleInmsb, bus.myRegSampleInlsb};
    sample_ext_s = {sample_s[15], sample_s};
    // 17-bit negate so that -32768 yields +32768 without overflow
    if (sample_s[15]) begin
      abs_s = 17'd0 - sample_ext_s;
    end else begin
      abs_s = sample_ext_s;
    end
    acc_next_s = acc_r + ACC_W'(abs_s);
    // The first sample of a frame has no predecessor to compare against
    if ((cnt_r != {CNT_W{1'b0}}) && (sample_s[15] != prev_neg_r)) begin
      cross_next_s = cross_r + 8'd1;
    end else begin
      cross_next_s = cross_r;
    end
    result_next_s = acc_next_s[ACC_W-1:LOG_N];
    capture_s     = (state_r == ST_WAIT_SAMPLE) && valid_s && !abort_s;
    last_s        = (cnt_r == LAST_IDX);
  end

  // Next-state logic; ABORT overrides everything else
  always_comb begin
    state_next_s = state_r;
    if (abort_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_rise_s) begin
            state_next_s = ST_WAIT_SAMPLE;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_WAIT_SAMPLE: begin
          if (valid_s) begin
            // The final capture skips the release phase
            state_next_s = last_s ? ST_DONE : ST_WAIT_RELEASE;
          end else begin
            state_next_s = ST_WAIT_SAMPLE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!valid_s && (cnt_r < FRAME_LEN)) begin
            state_next_s = ST_WAIT_SAMPLE;
          end else begin
            state_next_s = ST_WAIT_RELEASE;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // A new frame begins whenever IDLE/DONE hands over to WAIT_SAMPLE
  always_comb begin
    enter_frame_s = (state_next_s == ST_WAIT_SAMPLE) &&
                    ((state_r == ST_IDLE) || (state_r == ST_DONE));
  end

  // State, status image and START history
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      status_r     <= 8'h01;
      start_prev_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      status_r     <= status_of(state_next_s);
      start_prev_r <= start_s;
    end
  end

  // Frame accumulation state; untouched on ABORT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      cross_r    <= 8'd0;
      prev_neg_r <= 1'b0;
    end else if (enter_frame_s) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      cross_r    <= 8'd0;
      prev_neg_r <= 1'b0;
    end else if (capture_s) begin
      cnt_r      <= cnt_r + CNT_W'(1);
      acc_r      <= acc_next_s;
      cross_r    <= cross_next_s;
      prev_neg_r <= sample_s[15];
    end
  end

  // Result registers load on the final capture and hold until the next one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_r <= 16'd0;
      zc_r     <= 8'd0;
    end else if (capture_s && last_s) begin
      result_r <= result_next_s;
      zc_r     <= cross_next_s;
    end
  end

  assign bus.myRegASICStatuslsb = status_r;
  assign bus.myRegASICStatusmsb = zc_r;
  assign bus.myRegResultslsb    = result_r[7:0];
  assign bus.myRegResultsmsb    = result_r[15:8];

endmodule

// File: tb/tb_control_module.sv
// tb_control_module
//   Randomised and directed frames against a plain-arithmetic reference model;
//   expected frame results are queued by the driver and checked by a
//   separate monitor whenever DONE rises.
module tb_control_module;
  logic clk = 1'b0;
  logic reset_n;
  control_module_if bus();

  control_module #(.N_SAMPLES(128), .LOG_N(7)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  zc;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  longint m_sum;
  int     m_zc;
  int     m_n;
  bit     m_prev_neg;

  bit ctl_abort, ctl_start, ctl_valid;
  logic [7:0] junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive();
    junk = 8'($urandom);
    bus.myRegMCUStatusmsb = junk;
    bus.myRegMCUStatuslsb = {junk[7:4], ctl_valid, ctl_start, junk[1], ctl_abort};
  endtask

  task automatic model_reset();
    m_sum = 0; m_zc = 0; m_n = 0; m_prev_neg = 0;
  endtask

  task automatic model_add(input logic [15:0] x);
    int v;
    bit neg;
    exp_t e;
    v = int'($signed(x));
    neg = (v < 0);
    m_sum += (neg ? -v : v);
    if (m_n > 0 && neg != m_prev_neg) m_zc++;
    m_prev_neg = neg;
    m_n++;
    if (m_n == 128) begin
      e.res = 16'(m_sum / 128);
      e.zc  = 8'(m_zc);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_sample(input logic [15:0] x);
    int w = 0;
    while (!bus.myRegASICStatuslsb[3] && w < 20) begin
      tick();
      w++;
    end
    if (!bus.myRegASICStatuslsb[3]) begin
      check("req_timeout", 32'(bus.myRegASICStatuslsb[3]), 32'd1);
      return;
    end
    bus.myRegSampleInlsb = x[7:0];
    bus.myRegSampleInmsb = x[15:8];
    ctl_valid = 1'b1;
    drive();
    model_add(x);
    tick();
    ctl_valid = 1'b0;
    drive();
  endtask

  task automatic start_frame();
    ctl_start = 1'b0; drive(); tick();
    ctl_start = 1'b1; drive(); tick();
    check("start_status", 32'(bus.myRegASICStatuslsb), 32'h0C);
    model_reset();
  endtask

  function automatic logic [15:0] rand_sample();
    logic [15:0] r;
    case ($urandom_range(0, 7))
      0: r = 16'h8000;
      1: r = 16'h7FFF;
      2: r = 16'h0000;
      3: r = 16'hFFFF;
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  task automatic check_outputs(input string name, input logic [7:0] lsb,
                               input logic [7:0] msb, input logic [15:0] res);
    check({name, "_status"}, 32'(bus.myRegASICStatuslsb), 32'(lsb));
    check({name, "_zc"},     32'(bus.myRegASICStatusmsb), 32'(msb));
    check({name, "_result"}, 32'({bus.myRegResultsmsb, bus.myRegResultslsb}), 32'(res));
  endtask

  // scoreboard monitor: compare on every DONE rising
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    logic d;
    exp_t e;
    d = bus.myRegASICStatuslsb[1];
    if (d && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("sb_done_without_frame", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 32'({bus.myRegResultsmsb, bus.myRegResultslsb}), 32'(e.res));
        check("sb_zc", 32'(bus.myRegASICStatusmsb), 32'(e.zc));
        check("sb_status", 32'(bus.myRegASICStatuslsb), 32'h02);
      end
    end
    prev_done = d;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_abort = 0; ctl_start = 0; ctl_valid = 0;
    bus.myRegSampleInlsb = 8'h00;
    bus.myRegSampleInmsb = 8'h00;
    drive();
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    check_outputs("reset", 8'h01, 8'h00, 16'h0000);
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", 32'(bus.myRegASICStatuslsb), 32'h01);

    // constant 0x0100
    start_frame();
    for (int i = 0; i < 128; i++) send_sample(16'h0100);
    check_outputs("frame_0100", 8'h02, 8'h00, 16'h0100);

    // START held high and VALID held high in DONE must not retrigger
    repeat (3) tick();
    check("start_held", 32'(bus.myRegASICStatuslsb), 32'h02);
    ctl_valid = 1'b1; drive();
    repeat (3) tick();
    check_outputs("valid_in_done", 8'h02, 8'h00, 16'h0100);
    ctl_valid = 1'b0; drive(); tick();

    // alternating 0x1000 / 0xF000
    start_frame();
    for (int i = 0; i < 128; i++) send_sample((i % 2) ? 16'hF000 : 16'h1000);
    check_outputs("frame_alt", 8'h02, 8'h7F, 16'h1000);

    // abort after 10 captures, with a START edge during ABORT
    start_frame();
    for (int i = 0; i < 10; i++) send_sample(rand_sample());
    ctl_abort = 1'b1; ctl_start = 1'b0; drive(); tick();
    check_outputs("abort", 8'h01, 8'h7F, 16'h1000);
    ctl_start = 1'b1; drive(); tick();
    check("abort_prio", 32'(bus.myRegASICStatuslsb), 32'h01);
    ctl_abort = 1'b0; drive(); tick();
    check("abort_release", 32'(bus.myRegASICStatuslsb), 32'h01);
    model_reset();

    start_frame();
    for (int i = 0; i < 128; i++) send_sample(16'h0010);
    check_outputs("frame_0010", 8'h02, 8'h00, 16'h0010);

    // all -32768
    start_frame();
    for (int i = 0; i < 128; i++) send_sample(16'h8000);
    check_outputs("frame_8000", 8'h02, 8'h00, 16'h8000);

    // handshake timing and mid-frame START pulse
    start_frame();
    bus.myRegSampleInlsb = 8'h34;
    bus.myRegSampleInmsb = 8'h12;
    ctl_valid = 1'b1; drive();
    model_add(16'h1234);
    tick();
    check("req_fall", 32'(bus.myRegASICStatuslsb), 32'h04);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("req_low_hold", 32'(bus.myRegASICStatuslsb), 32'h04);
    end
    ctl_valid = 1'b0; drive(); tick();
    check("req_rise", 32'(bus.myRegASICStatuslsb), 32'h0C);
    ctl_start = 1'b0; drive(); tick();
    ctl_start = 1'b1; drive(); tick();
    ctl_start = 1'b0; drive(); tick();
    check("start_ignored", 32'(bus.myRegASICStatuslsb), 32'h0C);
    for (int i = 1; i < 128; i++) send_sample(rand_sample());
    check("hs_done", 32'(bus.myRegASICStatuslsb), 32'h02);

    // reset mid-frame discards partial data
    start_frame();
    for (int i = 0; i < 5; i++) send_sample(rand_sample());
    ctl_start = 1'b0; drive();
    reset_n = 1'b0;
    tick();
    check_outputs("mid_reset", 8'h01, 8'h00, 16'h0000);
    reset_n = 1'b1;
    model_reset();
    tick();

    // random frames
    for (int f = 0; f < 3; f++) begin
      start_frame();
      for (int i = 0; i < 128; i++) send_sample(rand_sample());
      check("rand_done", 32'(bus.myRegASICStatuslsb), 32'h02);
    end

    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
